// File: rtl/exec_pkg.sv
// exec_pkg: shared encodings and the EX/MEM control payload for the execute stage.
//   ALU_* : ALU control codes understood by alu
//   md_op_t : multiply/divide unit operation codes
//   fwd_sel_t : operand forwarding mux selects
//   ex_mem_t : M-stage control fields (data fields are XLEN-wide and live beside it)
package exec_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MFHI  = 3'b101,
    MD_MFLO  = 3'b110
  } md_op_t;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUOUTM = 2'b10,
    FWD_RSVD    = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic regWrite;
    logic memtoReg;
    logic memWrite;
    logic branch;
    logic zero;
  } ex_mem_t;

endpackage

// File: rtl/alu.sv
// alu: combinational MIPS ALU.
//   srcA, srcB : operands
//   aluControl : operation (AND, OR, ADD, SUB, signed SLT; other codes give 0)
//   aluResult  : result
//   zero       : aluResult == 0
module alu
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [2:0]      aluControl,
  output logic [XLEN-1:0] aluResult,
  output logic            zero
);

  always_comb begin
    aluResult = '0;
    case (aluControl)
      ALU_AND: aluResult = srcA & srcB;
      ALU_OR:  aluResult = srcA | srcB;
      ALU_ADD: aluResult = srcA + srcB;
      ALU_SUB: aluResult = srcA - srcB;
      ALU_SLT: aluResult = XLEN'($signed(srcA) < $signed(srcB));
      default: aluResult = '0;
    endcase
  end

  assign zero = (aluResult == '0);

endmodule

// File: rtl/iter_mdu.sv
// iter_mdu: iterative multiply/divide unit with HI/LO registers.
// One shift-add or restoring-subtract step per cycle for XLEN cycles on operand
// magnitudes; sign correction is applied when HI/LO are written.
//   start : accept op with operands a/b (only honoured in IDLE)
//   op    : MULT/MULTU/DIV/DIVU
//   busy  : an operation is running
//   hi/lo : architectural HI/LO
module iter_mdu
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  md_op_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  typedef enum logic {IDLE, RUN} mdu_state_t;

  mdu_state_t        state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [2*XLEN-1:0] acc, accNext;        // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   opB, opBNext;        // mult: |multiplicand|; div: |divisor|
  logic [XLEN-1:0]   dividend, dividendNext;
  logic              isDiv, isDivNext;
  logic              negQ, negQNext;      // negate product / quotient
  logic              negR, negRNext;      // negate remainder
  logic              divZero, divZeroNext;
  logic [XLEN-1:0]   hiNext, loNext;

  logic              signedOp;
  logic [XLEN-1:0]   absA, absB;
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] mulNext, divNext, stepNext, prodFix;
  logic [XLEN-1:0]   resHi, resLo;

  assign busy = (state == RUN);

  // Operand magnitudes at issue
  assign signedOp = (op == MD_MULT) || (op == MD_DIV);
  assign absA = (signedOp && a[XLEN-1]) ? (-a) : a;
  assign absB = (signedOp && b[XLEN-1]) ? (-b) : b;

  // One iteration of either algorithm
  always_comb begin
    mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opB} : '0);
    mulNext  = {mulSum, acc[XLEN-1:1]};
    divShift = acc[2*XLEN-1:XLEN-1];
    divDiff  = divShift - {1'b0, opB};
    if (!divDiff[XLEN]) divNext = {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else                divNext = {divShift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    stepNext = isDiv ? divNext : mulNext;
  end

  // Sign-corrected results from the final step
  always_comb begin
    prodFix = negQ ? (-stepNext) : stepNext;
    resHi   = prodFix[2*XLEN-1:XLEN];
    resLo   = prodFix[XLEN-1:0];
    if (isDiv) begin
      if (divZero) begin
        resLo = '1;
        resHi = dividend;
      end else begin
        resLo = negQ ? (-stepNext[XLEN-1:0]) : stepNext[XLEN-1:0];
        resHi = negR ? (-stepNext[2*XLEN-1:XLEN]) : stepNext[2*XLEN-1:XLEN];
      end
    end
  end

  // Next-state and register updates
  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    accNext      = acc;
    opBNext      = opB;
    dividendNext = dividend;
    isDivNext    = isDiv;
    negQNext     = negQ;
    negRNext     = negR;
    divZeroNext  = divZero;
    hiNext       = hi;
    loNext       = lo;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext    = RUN;
          cntNext      = '0;
          isDivNext    = (op == MD_DIV) || (op == MD_DIVU);
          negQNext     = signedOp && (a[XLEN-1] ^ b[XLEN-1]);
          negRNext     = signedOp && a[XLEN-1];
          divZeroNext  = (b == '0);
          dividendNext = a;
          if ((op == MD_DIV) || (op == MD_DIVU)) begin
            accNext = {{XLEN{1'b0}}, absA};
            opBNext = absB;
          end else begin
            accNext = {{XLEN{1'b0}}, absB};
            opBNext = absA;
          end
        end
      end
      RUN: begin
        accNext = stepNext;
        cntNext = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          stateNext = IDLE;
          cntNext   = '0;
          hiNext    = resHi;
          loNext    = resLo;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opB      <= '0;
      dividend <= '0;
      isDiv    <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      divZero  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      acc      <= accNext;
      opB      <= opBNext;
      dividend <= dividendNext;
      isDiv    <= isDivNext;
      negQ     <= negQNext;
      negR     <= negRNext;
      divZero  <= divZeroNext;
      hi       <= hiNext;
      lo       <= loNext;
    end
  end

endmodule

// File: rtl/execute_stage_mdu.sv
// execute_stage_mdu: MIPS execute stage with operand forwarding, iterative MDU
// (HI/LO, mfhi/mflo) and a stall/flush-controlled EX/MEM register.
//   Inputs : *E decode controls/data, ForwardAE/BE, ResultW, StallM, FlushM
//   Outputs: MdBusyE (combinational stall request), registered *M stage outputs
module execute_stage_mdu
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            RegWriteE,
  input  logic            MemtoRegE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            RegDstE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      MdOpE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] SignImmE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [RA_W-1:0] RtE,
  input  logic [RA_W-1:0] RdE,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  input  logic            StallM,
  input  logic            FlushM,
  output logic            MdBusyE,
  output logic            ZeroM,
  output logic [XLEN-1:0] ALUOutM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCBranchM,
  output logic [RA_W-1:0] WriteRegM,
  output logic            RegWriteM,
  output logic            MemtoRegM,
  output logic            MemWriteM,
  output logic            BranchM
);

  md_op_t          mdOp;
  logic            mdArith, mdStart, mduBusy, zeroE;
  logic [XLEN-1:0] srcA, bReg, srcB, aluResult, aluOutE, pcBranchE, hiVal, loVal;
  logic [RA_W-1:0] writeRegE;
  ex_mem_t         exMemD, exMemQ;
  logic [XLEN-1:0] aluOutQ, writeDataQ, pcBranchQ;
  logic [RA_W-1:0] writeRegQ;

  assign mdOp = md_op_t'(MdOpE);

  // Forwarding muxes; the reserved select falls back to the register value
  always_comb begin
    case (fwd_sel_t'(ForwardAE))
      FWD_RESULTW: srcA = ResultW;
      FWD_ALUOUTM: srcA = aluOutQ;
      default:     srcA = RD1E;
    endcase
    case (fwd_sel_t'(ForwardBE))
      FWD_RESULTW: bReg = ResultW;
      FWD_ALUOUTM: bReg = aluOutQ;
      default:     bReg = RD2E;
    endcase
  end

  assign srcB      = ALUSrcE ? SignImmE : bReg;
  assign writeRegE = RegDstE ? RdE : RtE;
  assign pcBranchE = PCPlus4E + (SignImmE << 2);

  alu #(.XLEN(XLEN)) uAlu (
    .srcA      (srcA),
    .srcB      (srcB),
    .aluControl(ALUControlE),
    .aluResult (aluResult),
    .zero      (zeroE)
  );

  // MDU issue: only arithmetic ops start it, and never while E is stalled on it
  assign mdArith = (mdOp == MD_MULT) || (mdOp == MD_MULTU) ||
                   (mdOp == MD_DIV)  || (mdOp == MD_DIVU);
  assign MdBusyE = mduBusy && (mdOp != MD_NONE);
  assign mdStart = mdArith && !MdBusyE;

  iter_mdu #(.XLEN(XLEN)) uMdu (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mdStart),
    .op   (mdOp),
    .a    (srcA),
    .b    (bReg),
    .busy (mduBusy),
    .hi   (hiVal),
    .lo   (loVal)
  );

  always_comb begin
    aluOutE = aluResult;
    if (mdOp == MD_MFHI) aluOutE = hiVal;
    if (mdOp == MD_MFLO) aluOutE = loVal;
  end

  assign exMemD = '{regWrite: RegWriteE, memtoReg: MemtoRegE, memWrite: MemWriteE,
                    branch: BranchE, zero: zeroE};

  // EX/MEM register: flush > stall > MDU bubble > load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exMemQ     <= '0;
      aluOutQ    <= '0;
      writeDataQ <= '0;
      pcBranchQ  <= '0;
      writeRegQ  <= '0;
    end else if (FlushM || (!StallM && MdBusyE)) begin
      exMemQ     <= '0;
      aluOutQ    <= '0;
      writeDataQ <= '0;
      pcBranchQ  <= '0;
      writeRegQ  <= '0;
    end else if (!StallM) begin
      exMemQ     <= exMemD;
      aluOutQ    <= aluOutE;
      writeDataQ <= bReg;
      pcBranchQ  <= pcBranchE;
      writeRegQ  <= writeRegE;
    end
  end

  assign RegWriteM  = exMemQ.regWrite;
  assign MemtoRegM  = exMemQ.memtoReg;
  assign MemWriteM  = exMemQ.memWrite;
  assign BranchM    = exMemQ.branch;
  assign ZeroM      = exMemQ.zero;
  assign ALUOutM    = aluOutQ;
  assign WriteDataM = writeDataQ;
  assign PCBranchM  = pcBranchQ;
  assign WriteRegM  = writeRegQ;

endmodule
